// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types for the direct-mapped cache: CPU/memory/store interfaces,
// address-split constants and the controller state enum.
package cache_def;

    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 14;
    localparam int IDX_MSB  = 13;
    localparam int IDX_LSB  = 4;
    localparam int WORD_MSB = 3;
    localparam int WORD_LSB = 2;

    localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W = IDX_MSB - IDX_LSB + 1;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             we;
    } cache_req_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        COMPARE_TAG,
        WRITE_BACK,
        ALLOCATE
    } cache_state_e;

endpackage

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Owns only the
// state register and the tag-clear sweep counter; every store, memory and
// CPU-side output is decoded combinationally from state plus inputs.
module dm_cache_ctrl
    import cache_def::*;
#(
    parameter int NUM_LINES     = 1024,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    output mem_req_type    mem_req,
    input  mem_data_type   mem_data,
    input  cache_tag_type  tag_read,
    output cache_req_type  tag_req,
    output cache_tag_type  tag_write,
    input  cache_data_type data_read,
    output cache_req_type  data_req,
    output cache_data_type data_write
);

    // The sweep counter doubles as the tag-store index, so NUM_LINES is
    // expected to match the 10-bit index field.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    cache_state_e     state_q, state_d;
    logic [IDX_W-1:0] initCnt_q, initCnt_d;

    logic [IDX_W-1:0] cpuIndex;
    logic [TAG_W-1:0] cpuTag;
    logic [6:0]       wordOff;
    logic             isHit;
    logic             addr_unused;

    assign cpuIndex    = cpu_req.addr[IDX_MSB:IDX_LSB];
    assign cpuTag      = cpu_req.addr[TAG_MSB:TAG_LSB];
    assign wordOff     = {cpu_req.addr[WORD_MSB:WORD_LSB], 5'b0};
    assign isHit       = tag_read.valid && (tag_read.tag == cpuTag);
    assign addr_unused = ^cpu_req.addr[1:0];

    // State and sweep counter; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_ON_RESET) begin
                state_q <= INIT;
            end else begin
                state_q <= IDLE;
            end
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    // Next-state and output decode; everything is forced to zero while reset is held.
    always_comb begin
        state_d        = state_q;
        initCnt_d      = initCnt_q;
        cpu_res        = '0;
        mem_req        = '0;
        tag_req.index  = cpuIndex;
        tag_req.we     = 1'b0;
        tag_write      = '0;
        data_req.index = cpuIndex;
        data_req.we    = 1'b0;
        data_write     = '0;

        if (rst) begin
            tag_req.index  = '0;
            data_req.index = '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    tag_req.index = initCnt_q;
                    tag_req.we    = 1'b1;
                    initCnt_d     = initCnt_q + 1'b1;
                    if (initCnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end

                IDLE: begin
                    if (cpu_req.valid) begin
                        state_d = COMPARE_TAG;
                    end
                end

                COMPARE_TAG: begin
                    if (isHit) begin
                        cpu_res.ready = 1'b1;
                        if (cpu_req.rw) begin
                            data_req.we                = 1'b1;
                            data_write                 = data_read;
                            data_write[wordOff +: 32]  = cpu_req.data;
                            tag_req.we                 = 1'b1;
                            tag_write.valid            = 1'b1;
                            tag_write.dirty            = 1'b1;
                            tag_write.tag              = cpuTag;
                        end else begin
                            cpu_res.data = data_read[wordOff +: 32];
                        end
                        state_d = IDLE;
                    end else if (tag_read.valid && tag_read.dirty) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end

                WRITE_BACK: begin
                    mem_req.addr  = {tag_read.tag, cpuIndex, 4'b0};
                    mem_req.data  = data_read;
                    mem_req.rw    = 1'b1;
                    mem_req.valid = 1'b1;
                    if (mem_data.ready) begin
                        state_d = ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    mem_req.addr  = {cpu_req.addr[31:4], 4'b0};
                    mem_req.rw    = 1'b0;
                    mem_req.valid = 1'b1;
                    if (mem_data.ready) begin
                        data_req.we     = 1'b1;
                        data_write      = mem_data.data;
                        tag_req.we      = 1'b1;
                        tag_write.valid = 1'b1;
                        tag_write.dirty = 1'b0;
                        tag_write.tag   = cpuTag;
                        state_d         = COMPARE_TAG;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Once a request has been accepted the CPU must hold it unchanged until ready.
    property pCpuReqStable;
        @(posedge clk) disable iff (rst)
            (state_q != INIT && cpu_req.valid && !cpu_res.ready) |=> (cpu_req.valid && $stable(cpu_req));
    endproperty
    assert property (pCpuReqStable);

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: behavioural tag/data stores, a
// memory with programmable response time, and a CPU-visible memory model
// that predicts read data, response latency and memory traffic.
module tb_dm_cache_ctrl;
    import cache_def::*;

    localparam int NUM_LINES = 1024;

    typedef struct {
        logic [31:0]  addr;
        logic         rw;
        logic [127:0] data;
    } memOp_t;

    logic           clk = 1'b0;
    logic           rst;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;
    cache_tag_type  tag_read;
    cache_req_type  tag_req;
    cache_tag_type  tag_write;
    cache_data_type data_read;
    cache_req_type  data_req;
    cache_data_type data_write;

    int nCompared;
    int nMismatched;

    dm_cache_ctrl #(.NUM_LINES(NUM_LINES), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_res(cpu_res),
        .mem_req(mem_req), .mem_data(mem_data),
        .tag_read(tag_read), .tag_req(tag_req), .tag_write(tag_write),
        .data_read(data_read), .data_req(data_req), .data_write(data_write)
    );

    always #5 clk = ~clk;

    // Behavioural tag and data stores: combinational read, write on clock edge.
    cache_tag_type  tagArr  [NUM_LINES];
    cache_data_type dataArr [NUM_LINES];
    assign tag_read  = tagArr[tag_req.index];
    assign data_read = dataArr[data_req.index];

    always @(posedge clk) begin
        if (tag_req.we)  tagArr[tag_req.index]   <= tag_write;
        if (data_req.we) dataArr[data_req.index] <= data_write;
    end

    // Backing memory contents are a fixed function of address until written.
    function automatic logic [31:0] initWord(input logic [29:0] wa);
        return {wa, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    logic [127:0] backMem [logic [27:0]];
    logic [31:0]  refMem  [logic [29:0]];

    function automatic logic [127:0] memLine(input logic [27:0] la);
        logic [127:0] l;
        if (backMem.exists(la)) return backMem[la];
        for (int k = 0; k < 4; k++) l[32*k +: 32] = initWord({la, 2'(k)});
        return l;
    endfunction

    function automatic logic [31:0] refWord(input logic [29:0] wa);
        if (refMem.exists(wa)) return refMem[wa];
        return initWord(wa);
    endfunction

    function automatic logic [127:0] refLine(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = refWord({la, 2'(k)});
        return l;
    endfunction

    // Memory responder: ready on the tMem-th cycle a request is presented.
    int           tMem;
    int           memCnt;
    logic         memReady;
    logic [127:0] memRdData;
    logic         forceReady;
    logic [127:0] forceData;
    assign mem_data.ready = memReady | forceReady;
    assign mem_data.data  = forceReady ? forceData : memRdData;

    initial begin
        memReady  = 1'b0;
        memRdData = '0;
        memCnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            memReady  = 1'b0;
            memRdData = '0;
            if (mem_req.valid) begin
                memCnt++;
                if (memCnt >= tMem) begin
                    memCnt   = 0;
                    memReady = 1'b1;
                    if (mem_req.rw) backMem[mem_req.addr[31:4]] = mem_req.data;
                    else            memRdData = memLine(mem_req.addr[31:4]);
                end
            end else begin
                memCnt = 0;
            end
        end
    end

    // Abstract cache occupancy model used to predict hit/miss and latency.
    logic        refValid [NUM_LINES];
    logic        refDirty [NUM_LINES];
    logic [17:0] refTag   [NUM_LINES];
    memOp_t      expOps[$];

    logic        initActive;
    int          initIdx;
    logic        txnActive;
    int          txnCyc;
    int          expLat;
    logic        expRw;
    logic [31:0] expData;
    logic [31:0] lastData;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model's predictions.
    always @(negedge clk) begin
        if (!rst) begin
            if (initActive) begin
                if (initIdx < NUM_LINES) begin
                    checkOutput("init_tag_we", tag_req.we, 1'b1);
                    checkOutput("init_tag_index", tag_req.index, initIdx);
                    checkOutput("init_tag_wdata", tag_write, '0);
                    initIdx++;
                end else begin
                    checkOutput("init_done_we", tag_req.we, 1'b0);
                    initActive = 1'b0;
                end
            end
            if (txnActive) begin
                txnCyc++;
                checkOutput("cpu_ready_timing", cpu_res.ready, (txnCyc == expLat));
                if (txnCyc == expLat) begin
                    if (!expRw) checkOutput("cpu_rdata", cpu_res.data, expData);
                    lastData  = cpu_res.data;
                    txnActive = 1'b0;
                end
            end else begin
                checkOutput("cpu_ready_idle", cpu_res.ready, 1'b0);
            end
            if (!cpu_res.ready) checkOutput("cpu_data_zero", cpu_res.data, '0);
            if (mem_req.valid) begin
                if (expOps.size() == 0) begin
                    checkOutput("mem_unexpected_valid", mem_req.valid, 1'b0);
                end else begin
                    checkOutput("mem_addr", mem_req.addr, expOps[0].addr);
                    checkOutput("mem_rw", mem_req.rw, expOps[0].rw);
                    if (expOps[0].rw) checkOutput("mem_wb_data", mem_req.data, expOps[0].data);
                    if (mem_data.ready) void'(expOps.pop_front());
                end
            end
        end
    end

    // Predict the outcome of one CPU access, drive it, and wait for completion.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic rw);
        logic [9:0]  idx;
        logic [17:0] tg;
        logic        hit;
        int          budget;
        memOp_t      op;
        idx = addr[13:4];
        tg  = addr[31:14];
        hit = refValid[idx] && (refTag[idx] == tg);
        expOps.delete();
        if (hit) begin
            expLat = 2;
        end else begin
            if (refValid[idx] && refDirty[idx]) begin
                op.addr = {refTag[idx], idx, 4'b0};
                op.rw   = 1'b1;
                op.data = refLine({refTag[idx], idx});
                expOps.push_back(op);
                expLat = 3 + 2 * tMem;
            end else begin
                expLat = 3 + tMem;
            end
            op.addr = {addr[31:4], 4'b0};
            op.rw   = 1'b0;
            op.data = '0;
            expOps.push_back(op);
        end
        expRw   = rw;
        expData = refWord(addr[31:2]);
        refDirty[idx] = (hit && refDirty[idx]) || rw;
        refValid[idx] = 1'b1;
        refTag[idx]   = tg;
        if (rw) refMem[addr[31:2]] = data;

        @(posedge clk);
        #1;
        cpu_req.addr  = addr;
        cpu_req.data  = data;
        cpu_req.rw    = rw;
        cpu_req.valid = 1'b1;
        txnCyc    = 0;
        txnActive = 1'b1;
        budget    = 0;
        while (txnActive && budget < 300) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (txnActive) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL txn_timeout: addr 0x%0h got no completion, expected one within 300 cycles", addr);
            txnActive = 1'b0;
        end
        @(posedge clk);
        #1;
        cpu_req.valid = 1'b0;
    endtask

    task automatic waitInit();
        int budget;
        budget = 0;
        while (initActive && budget < NUM_LINES + 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (initActive) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL init_timeout: sweep still running, expected done after %0d cycles", NUM_LINES);
            initActive = 1'b0;
        end
    endtask

    task automatic clearRefCache();
        for (int i = 0; i < NUM_LINES; i++) begin
            refValid[i] = 1'b0;
            refDirty[i] = 1'b0;
            refTag[i]   = '0;
        end
    endtask

    // Directed scenario sequence.
    initial begin
        cache_data_type savedLine;
        nCompared   = 0;
        nMismatched = 0;
        initActive  = 1'b0;
        initIdx     = 0;
        txnActive   = 1'b0;
        txnCyc      = 0;
        expLat      = 0;
        expRw       = 1'b0;
        expData     = '0;
        lastData    = '0;
        forceReady  = 1'b0;
        forceData   = '0;
        tMem        = 3;
        rst         = 1'b1;
        cpu_req     = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            tagArr[i]  = {1'b1, 1'b1, 18'(i)};
            dataArr[i] = {4{32'hBAD0_0000 | 32'(i)}};
        end
        clearRefCache();

        // Reset and tag sweep, with a CPU request held during the sweep.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_zero",
                    |{cpu_res, mem_req, tag_req, tag_write, data_req, data_write}, 1'b0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        initActive    = 1'b1;
        initIdx       = 0;
        cpu_req.addr  = 32'h0000_1234;
        cpu_req.valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        cpu_req.valid = 1'b0;
        waitInit();
        checkOutput("t1_tag0_cleared", tagArr[0], '0);
        checkOutput("t1_tag123_cleared", tagArr[10'h123], '0);
        checkOutput("t1_tag1023_cleared", tagArr[1023], '0);

        // Cold read miss, clean allocate.
        applyStimulus(32'h0000_1234, 32'h0, 1'b0);
        checkOutput("t2_latency_pin", expLat, 6);
        checkOutput("t2_rdata_pin", lastData, 32'h5A5A_1234);
        checkOutput("t2_tag_pin", tagArr[10'h123], 20'h8_0000);

        // Write hit on the freshly filled line.
        applyStimulus(32'h0000_1238, 32'hDEAD_BEEF, 1'b1);
        checkOutput("t3_tag_dirty_pin", tagArr[10'h123], 20'hC_0000);
        checkOutput("t3_word2_pin", dataArr[10'h123][95:64], 32'hDEAD_BEEF);
        checkOutput("t3_word0_pin", dataArr[10'h123][31:0], 32'h5A5A_1230);

        // Conflicting read: dirty victim write-back then allocate.
        applyStimulus(32'h0000_5234, 32'h0, 1'b0);
        checkOutput("t4_latency_pin", expLat, 9);
        checkOutput("t4_rdata_pin", lastData, 32'h5A5A_5234);
        checkOutput("t4_tag_pin", tagArr[10'h123], 20'h8_0001);
        checkOutput("t4_wb_word2_pin", backMem[28'h123][95:64], 32'hDEAD_BEEF);

        // Reset while an allocate is waiting with a memory response pending.
        tMem = 50;
        expOps.delete();
        expOps.push_back('{addr: 32'h0000_2040, rw: 1'b0, data: '0});
        expLat  = 53;
        expRw   = 1'b0;
        expData = initWord(30'(32'h0000_2040 >> 2));
        @(posedge clk);
        #1;
        cpu_req.addr  = 32'h0000_2040;
        cpu_req.data  = 32'h0;
        cpu_req.rw    = 1'b0;
        cpu_req.valid = 1'b1;
        txnCyc    = 0;
        txnActive = 1'b1;
        repeat (4) @(negedge clk);
        savedLine = dataArr[4];
        @(posedge clk);
        #1;
        rst        = 1'b1;
        forceReady = 1'b1;
        forceData  = {4{32'h1111_2222}};
        txnActive  = 1'b0;
        expOps.delete();
        @(negedge clk);
        checkOutput("t5_rst_tag_we", tag_req.we, 1'b0);
        checkOutput("t5_rst_data_we", data_req.we, 1'b0);
        checkOutput("t5_rst_mem_valid", mem_req.valid, 1'b0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        forceReady    = 1'b0;
        cpu_req.valid = 1'b0;
        initActive    = 1'b1;
        initIdx       = 0;
        tMem          = 3;
        clearRefCache();
        checkOutput("t5_no_stale_tag", tagArr[4], '0);
        checkOutput("t5_no_stale_data", dataArr[4], savedLine);
        @(negedge clk);
        checkOutput("t5_mem_valid_dropped", mem_req.valid, 1'b0);
        waitInit();

        // Write miss to a clean line: fill, then merge on the hit.
        applyStimulus(32'h0000_0008, 32'hCAFE_F00D, 1'b1);
        checkOutput("t6_tag_pin", tagArr[0], 20'hC_0000);
        checkOutput("t6_word2_pin", dataArr[0][95:64], 32'hCAFE_F00D);
        checkOutput("t6_word0_pin", dataArr[0][31:0], 32'h5A5A_0000);

        // Read back the merged word, then evict it with a fast memory.
        applyStimulus(32'h0000_0008, 32'h0, 1'b0);
        checkOutput("t7_rdata_pin", lastData, 32'hCAFE_F00D);
        tMem = 1;
        applyStimulus(32'h0000_4004, 32'h0, 1'b0);
        checkOutput("t8_latency_pin", expLat, 5);
        checkOutput("t8_rdata_pin", lastData, 32'h5A5A_4004);
        checkOutput("t8_wb_word2_pin", backMem[28'h0][95:64], 32'hCAFE_F00D);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at 1000000 ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
